// File: rtl/str_streamer_pkg.sv
// Shared types and character constants for the string streamer.
package str_streamer_pkg;

    typedef enum logic [1:0] {IDLE, CHAR, TERM, LF} state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/str_streamer.sv
// Streams a latched packed string one character per transfer, then a terminator
// (and optional LF), over a valid/ready interface with registered outputs.
module str_streamer
    import str_streamer_pkg::*;
#(
    parameter int                N_CHARS   = 8,
    parameter int                CHAR_W    = 8,
    parameter logic [CHAR_W-1:0] TERM_CHAR = CHAR_W'(CHAR_CR),
    parameter bit                ADD_LF    = 1'b0,
    parameter bit                SKIP_NUL  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_CHARS*CHAR_W-1:0] str_in,
    output logic [CHAR_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int               IDX_W = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_CHARS - 1);

    state_t                           state, state_n;
    logic [IDX_W-1:0]                 idx, idx_n, idx_inc;
    logic [N_CHARS-1:0][CHAR_W-1:0]   shadow, shadow_n;
    logic [CHAR_W-1:0]                data_n, char0, char_nxt;
    logic                             valid_n, done_n, xfer;

    function automatic logic skip(input logic [CHAR_W-1:0] c);
        return SKIP_NUL && (c == '0);
    endfunction

    assign xfer     = out_valid && out_ready;
    assign idx_inc  = idx + IDX_W'(1);
    assign char0    = str_in[CHAR_W-1:0];
    assign char_nxt = shadow[idx_inc];
    assign busy     = (state != IDLE);

    // out_data/out_valid always hold the character at idx; valid low in CHAR marks a skip cycle
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        shadow_n = shadow;
        data_n   = out_data;
        valid_n  = out_valid;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = CHAR;
                    shadow_n = str_in;
                    idx_n    = '0;
                    data_n   = char0;
                    valid_n  = !skip(char0);
                end
            end
            CHAR: begin
                if (xfer || !out_valid) begin
                    if (idx == LAST) begin
                        state_n = TERM;
                        data_n  = TERM_CHAR;
                        valid_n = 1'b1;
                    end else begin
                        idx_n   = idx_inc;
                        data_n  = char_nxt;
                        valid_n = !skip(char_nxt);
                    end
                end
            end
            TERM: begin
                if (xfer) begin
                    if (ADD_LF) begin
                        state_n = LF;
                        data_n  = CHAR_W'(CHAR_LF);
                        valid_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
            LF: begin
                if (xfer) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            shadow    <= shadow_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_str_streamer.sv
// Directed bench: dut_a uses defaults (no LF), dut_b adds LF; both N_CHARS=4.
module tb_str_streamer;

    logic        clk, rst, start_a, start_b, out_ready;
    logic [31:0] str_in;
    logic [7:0]  data_a, data_b;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    int          checks = 0;
    int          errors = 0;

    localparam bit A = 1'b0;
    localparam bit B = 1'b1;

    str_streamer #(.N_CHARS(4), .CHAR_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .str_in(str_in),
        .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
        .busy(busy_a), .done(done_a)
    );

    str_streamer #(.N_CHARS(4), .CHAR_W(8), .ADD_LF(1'b1), .SKIP_NUL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .str_in(str_in),
        .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
        .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // check one cycle of a DUT's outputs, then advance a cycle
    task automatic cyc(input string tag, input bit sel, input logic v, input logic [7:0] d,
                       input logic bz, input logic dn);
        logic       ov, ob, od;
        logic [7:0] odat;
        ov   = sel ? valid_b : valid_a;
        odat = sel ? data_b  : data_a;
        ob   = sel ? busy_b  : busy_a;
        od   = sel ? done_b  : done_a;
        chk({tag, " valid"}, 32'(ov), 32'(v));
        if (v) chk({tag, " data"}, 32'(odat), 32'(d));
        chk({tag, " busy"}, 32'(ob), 32'(bz));
        chk({tag, " done"}, 32'(od), 32'(dn));
        go();
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; str_in = '0; out_ready = 1'b1;
        go(); go();
        chk("reset data a", 32'(data_a), 0);
        chk("reset data b", 32'(data_b), 0);
        cyc("reset a", A, 0, 8'h00, 0, 0);
        rst = 1'b0;
        go();

        // basic
        str_in = 32'h44434241; start_a = 1'b1; go(); start_a = 1'b0;
        cyc("basic c1", A, 1, 8'h41, 1, 0);
        cyc("basic c2", A, 1, 8'h42, 1, 0);
        cyc("basic c3", A, 1, 8'h43, 1, 0);
        cyc("basic c4", A, 1, 8'h44, 1, 0);
        cyc("basic c5", A, 1, 8'h0D, 1, 0);
        cyc("basic c6", A, 0, 8'h00, 0, 1);
        cyc("basic c7", A, 0, 8'h00, 0, 0);

        // backpressure on the second character
        start_a = 1'b1; go(); start_a = 1'b0;
        cyc("bp c1", A, 1, 8'h41, 1, 0);
        out_ready = 1'b0;
        cyc("bp c2", A, 1, 8'h42, 1, 0);
        cyc("bp c3", A, 1, 8'h42, 1, 0);
        cyc("bp c4", A, 1, 8'h42, 1, 0);
        out_ready = 1'b1;
        cyc("bp c5", A, 1, 8'h42, 1, 0);
        cyc("bp c6", A, 1, 8'h43, 1, 0);
        cyc("bp c7", A, 1, 8'h44, 1, 0);
        cyc("bp c8", A, 1, 8'h0D, 1, 0);
        cyc("bp c9", A, 0, 8'h00, 0, 1);
        cyc("bp c10", A, 0, 8'h00, 0, 0);

        // skipped NULs and trailing LF
        str_in = 32'h00430041; start_b = 1'b1; go(); start_b = 1'b0;
        cyc("skip c1", B, 1, 8'h41, 1, 0);
        cyc("skip c2", B, 0, 8'h00, 1, 0);
        cyc("skip c3", B, 1, 8'h43, 1, 0);
        cyc("skip c4", B, 0, 8'h00, 1, 0);
        cyc("skip c5", B, 1, 8'h0D, 1, 0);
        cyc("skip c6", B, 1, 8'h0A, 1, 0);
        cyc("skip c7", B, 0, 8'h00, 0, 1);
        cyc("skip c8", B, 0, 8'h00, 0, 0);

        // all-zero string emits only CR LF
        str_in = 32'h0; start_b = 1'b1; go(); start_b = 1'b0;
        cyc("zero c1", B, 0, 8'h00, 1, 0);
        cyc("zero c2", B, 0, 8'h00, 1, 0);
        cyc("zero c3", B, 0, 8'h00, 1, 0);
        cyc("zero c4", B, 0, 8'h00, 1, 0);
        cyc("zero c5", B, 1, 8'h0D, 1, 0);
        cyc("zero c6", B, 1, 8'h0A, 1, 0);
        cyc("zero c7", B, 0, 8'h00, 0, 1);
        cyc("zero c8", B, 0, 8'h00, 0, 0);

        // start while busy is ignored
        str_in = 32'h44434241; start_a = 1'b1; go();
        str_in = 32'h55555555;
        cyc("busy c1", A, 1, 8'h41, 1, 0);
        start_a = 1'b0;
        cyc("busy c2", A, 1, 8'h42, 1, 0);
        cyc("busy c3", A, 1, 8'h43, 1, 0);
        cyc("busy c4", A, 1, 8'h44, 1, 0);
        cyc("busy c5", A, 1, 8'h0D, 1, 0);
        cyc("busy c6", A, 0, 8'h00, 0, 1);
        cyc("busy c7", A, 0, 8'h00, 0, 0);
        cyc("busy c8", A, 0, 8'h00, 0, 0);

        // reset mid-string aborts, then a fresh start works
        str_in = 32'h44434241; start_a = 1'b1; go(); start_a = 1'b0;
        cyc("abort c1", A, 1, 8'h41, 1, 0);
        cyc("abort c2", A, 1, 8'h42, 1, 0);
        rst = 1'b1;
        cyc("abort c3", A, 1, 8'h43, 1, 0);
        rst = 1'b0;
        chk("abort data cleared", 32'(data_a), 0);
        cyc("abort c4", A, 0, 8'h00, 0, 0);
        cyc("abort c5", A, 0, 8'h00, 0, 0);
        cyc("abort c6", A, 0, 8'h00, 0, 0);
        str_in = 32'h64636261; start_a = 1'b1; go(); start_a = 1'b0;
        cyc("restart c1", A, 1, 8'h61, 1, 0);
        cyc("restart c2", A, 1, 8'h62, 1, 0);
        cyc("restart c3", A, 1, 8'h63, 1, 0);
        cyc("restart c4", A, 1, 8'h64, 1, 0);
        cyc("restart c5", A, 1, 8'h0D, 1, 0);
        cyc("restart c6", A, 0, 8'h00, 0, 1);

        // reset wins over start in the same cycle
        rst = 1'b1; start_a = 1'b1; go();
        rst = 1'b0; start_a = 1'b0;
        cyc("rst_ovr c1", A, 0, 8'h00, 0, 0);
        cyc("rst_ovr c2", A, 0, 8'h00, 0, 0);

        // start held high: back-to-back strings
        str_in = 32'h44434241; start_a = 1'b1; go();
        cyc("b2b c1", A, 1, 8'h41, 1, 0);
        cyc("b2b c2", A, 1, 8'h42, 1, 0);
        cyc("b2b c3", A, 1, 8'h43, 1, 0);
        cyc("b2b c4", A, 1, 8'h44, 1, 0);
        cyc("b2b c5", A, 1, 8'h0D, 1, 0);
        cyc("b2b c6", A, 0, 8'h00, 0, 1);
        cyc("b2b c7", A, 1, 8'h41, 1, 0);
        cyc("b2b c8", A, 1, 8'h42, 1, 0);
        cyc("b2b c9", A, 1, 8'h43, 1, 0);
        cyc("b2b c10", A, 1, 8'h44, 1, 0);
        cyc("b2b c11", A, 1, 8'h0D, 1, 0);
        start_a = 1'b0;
        cyc("b2b c12", A, 0, 8'h00, 0, 1);
        cyc("b2b c13", A, 0, 8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/str_streamer.md
STR_STREAMER -- requirements
Module: str_streamer

Interface
REQ-001 The block SHALL have parameter N_CHARS, default 8: number of characters in the string input, 1..16.
REQ-002 The block SHALL have parameter CHAR_W, default 8: character width in bits.
REQ-003 The block SHALL have parameter TERM_CHAR, default 8'h0D: terminator emitted after the string.
REQ-004 The block SHALL have parameter ADD_LF, default 0: when 1, 8'h0A is emitted after TERM_CHAR.
REQ-005 The block SHALL have parameter SKIP_NUL, default 1: when 1, characters equal to 0 are not emitted.
REQ-006 The block SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 The block SHALL have port start, input, 1 bit: request to send the string present on str_in.
REQ-009 The block SHALL have port str_in, input, N_CHARS*CHAR_W bits: packed string, character 0 in the LSBs.
REQ-010 The block SHALL have port out_data, output, CHAR_W bits: character being offered, registered.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data is valid, registered.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_data.
REQ-013 The block SHALL have port busy, output, 1 bit: a string is in progress (state not IDLE).
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final character transfers.

Function
REQ-015 A transfer SHALL occur on every rising edge where out_valid=1 and out_ready=1.
REQ-016 Once out_valid is asserted, out_valid and out_data SHALL stay stable until a transfer occurs.
REQ-017 start SHALL be accepted only when the state is IDLE, including the cycle in which done is high.
REQ-018 On acceptance, str_in SHALL be copied into a shadow register and the character index cleared to 0; str_in is then don't-care until done.
REQ-019 The FSM SHALL have four states: IDLE, CHAR, TERM, LF.
REQ-020 Transitions SHALL be: IDLE->CHAR on an accepted start; CHAR->TERM after the transfer of index N_CHARS-1, or after a skip of that index; TERM->LF on transfer if ADD_LF=1; TERM->IDLE on transfer if ADD_LF=0; LF->IDLE on transfer.
REQ-021 The first character SHALL be offered (out_valid=1) in the cycle after start is accepted, given that character is not skipped.
REQ-022 In CHAR with SKIP_NUL=1, a zero character SHALL consume one cycle with out_valid=0 and advance the index.
REQ-023 With SKIP_NUL=0, zero characters SHALL be emitted as normal data.
REQ-024 With out_ready held high, the block SHALL sustain one character per cycle with no bubbles, except bubbles caused by skipped characters.
REQ-025 done SHALL be 1 for exactly one cycle: the cycle after the final transfer (TERM, or LF when ADD_LF=1).
REQ-026 busy SHALL fall in that same cycle.
REQ-027 start while busy=1 SHALL be ignored; it SHALL NOT be queued and SHALL NOT restart the string.
REQ-028 A string of all zeros with SKIP_NUL=1 SHALL emit only the terminator, plus LF when ADD_LF=1.
REQ-029 The character index SHALL be $clog2(N_CHARS) bits wide, minimum 1, and SHALL never exceed N_CHARS-1.

Reset
REQ-030 On rst=1, state SHALL go to IDLE and index to 0.
REQ-031 On rst=1, out_valid, busy and done SHALL go to 0.
REQ-032 On rst=1, out_data and the shadow register SHALL go to 0.
REQ-033 rst SHALL override start in the same cycle.
REQ-034 rst mid-string SHALL abort the string: no further characters and no done pulse.

Structure
REQ-035 A package str_streamer_pkg SHALL hold the state enumeration and the constants CHAR_CR=8'h0D and CHAR_LF=8'h0A.
REQ-036 The shadow register and character select SHALL live in the top module; no sub-module is required.

Verification
REQ-037 Basic: N_CHARS=4, str_in=32'h44434241, out_ready=1, start pulsed at cycle 0 -> out_data 41,42,43,44,0D on cycles 1-5, done=1 at cycle 6, busy=0 at cycle 6.
REQ-038 Backpressure: same stimulus, out_ready low for 3 cycles at the second character -> 42 held stable with out_valid=1 for those 3 cycles, no character lost or duplicated, done at cycle 9.
REQ-039 Skip and LF: SKIP_NUL=1, ADD_LF=1, str_in=32'h00430041 -> emits 41,43,0D,0A; a valid-low bubble at each zero character; done after the 0A transfer.
REQ-040 Busy start: a second start with different str_in during CHAR -> the original string completes unchanged, and exactly one done pulse occurs.
REQ-041 Reset abort: rst asserted while 43 is offered -> the next cycle has out_valid=0 and busy=0, and done stays 0; a new start then works normally.
REQ-042 Back-to-back: start held high continuously -> the second string begins in the cycle after done, and exactly one done pulse occurs per string.
